// File: rtl/spi_config_controller.sv
// SPI mode-0 bus master that serialises one WORD_BITS configuration word per request, MSB first.
// Optional miso capture is built only when SPI_CTRL_RX_EN is defined; otherwise rx_data is tied to 0.
module spi_config_controller #(
  parameter int CLK_DIV   = 4,
  parameter int WORD_BITS = 32,
  parameter int SS_SETUP  = 2,
  parameter int SS_HOLD   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 done,
  output logic                 busy,
  output logic                 ss_n,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int CNT_MAX_A = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
  localparam int CNT_MAX   = ((CNT_MAX_A > SS_HOLD) ? CNT_MAX_A : SS_HOLD) - 1;
  localparam int CNT_W     = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int BIT_W     = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  localparam logic [CNT_W-1:0] DIV_RELOAD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_RELOAD = CNT_W'(SS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_RELOAD  = CNT_W'(SS_HOLD - 1);
  localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(WORD_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
  logic                 sclk_d, ss_n_d, mosi_d, done_d;
  logic [WORD_BITS-1:0] tx_sr, tx_sr_d;
  logic                 accept;

`ifdef SPI_CTRL_RX_EN
  logic [WORD_BITS-1:0] rx_sr, rx_sr_d;
  logic [WORD_BITS-1:0] rx_data_q, rx_data_d;
  assign rx_data = rx_data_q;
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_data     = '0;
`endif

  // The done cycle is still "busy"; ready only returns the cycle after.
  assign tx_ready = (state == IDLE) && !done;
  assign busy     = !tx_ready;
  assign accept   = tx_valid && tx_ready;

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_cnt_d = bit_cnt;
    sclk_d    = sclk;
    ss_n_d    = ss_n;
    mosi_d    = mosi;
    done_d    = 1'b0;
    tx_sr_d   = tx_sr;
`ifdef SPI_CTRL_RX_EN
    rx_sr_d   = rx_sr;
    rx_data_d = rx_data_q;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          tx_sr_d = tx_data;
          state_d = START;
        end
      end
      START: begin
        ss_n_d  = 1'b0;
        mosi_d  = tx_sr[WORD_BITS-1];
        cnt_d   = SETUP_RELOAD;
        state_d = SETUP;
      end
      SETUP: begin
        if (cnt == '0) begin
          cnt_d     = DIV_RELOAD;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          cnt_d = DIV_RELOAD;
          if (!sclk) begin
            sclk_d = 1'b1;
`ifdef SPI_CTRL_RX_EN
            rx_sr_d = {rx_sr[WORD_BITS-2:0], miso};
`endif
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt == LAST_BIT) begin
              cnt_d   = HOLD_RELOAD;
              state_d = HOLD;
            end else begin
              bit_cnt_d = bit_cnt + 1'b1;
              tx_sr_d   = tx_sr << 1;
              mosi_d    = tx_sr[WORD_BITS-2];
            end
          end
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          ss_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef SPI_CTRL_RX_EN
          rx_data_d = rx_sr;
`endif
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      ss_n    <= 1'b1;
      mosi    <= 1'b0;
      done    <= 1'b0;
`ifdef SPI_CTRL_RX_EN
      rx_data_q <= '0;
`endif
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_cnt <= bit_cnt_d;
      sclk    <= sclk_d;
      ss_n    <= ss_n_d;
      mosi    <= mosi_d;
      done    <= done_d;
`ifdef SPI_CTRL_RX_EN
      rx_data_q <= rx_data_d;
`endif
    end
  end

  // Shift registers carry data only; their contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    tx_sr <= tx_sr_d;
`ifdef SPI_CTRL_RX_EN
    rx_sr <= rx_sr_d;
`endif
  end

endmodule

// File: tb/tb_spi_config_controller.sv
// Directed scoreboard bench for spi_config_controller: default-parameter instance plus a fast
// CLK_DIV=1/SS_SETUP=1/SS_HOLD=1 instance; rx expectations follow SPI_CTRL_RX_EN.
module tb_spi_config_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tx_data = 32'h0;
  logic        tx_valid = 1'b0;
  logic        sel = 1'b0;
  int          miso_sel = 0;
  logic        miso_rnd = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          last_done = 0;
  int          last_acc = 0;
  int          last_fall = 0;
  logic [32:0] sb_q[$];

  logic        a_ready, a_done, a_busy, a_ss_n, a_sclk, a_mosi, a_miso;
  logic [31:0] a_rx;
  logic        b_ready, b_done, b_busy, b_ss_n, b_sclk, b_mosi, b_miso;
  logic [31:0] b_rx;
  logic        m_ready, m_done, m_busy, m_ss_n, m_sclk, m_mosi, m_miso;
  logic [31:0] m_rx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      miso_rnd = 1'($urandom_range(0, 1));
    end
  end

  assign a_miso = (miso_sel == 2) ? a_mosi : (miso_sel == 3) ? miso_rnd : (miso_sel == 1);
  assign b_miso = (miso_sel == 2) ? b_mosi : (miso_sel == 3) ? miso_rnd : (miso_sel == 1);

  assign m_ready = sel ? b_ready : a_ready;
  assign m_done  = sel ? b_done  : a_done;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_ss_n  = sel ? b_ss_n  : a_ss_n;
  assign m_sclk  = sel ? b_sclk  : a_sclk;
  assign m_mosi  = sel ? b_mosi  : a_mosi;
  assign m_miso  = sel ? b_miso  : a_miso;
  assign m_rx    = sel ? b_rx    : a_rx;

  spi_config_controller dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid && !sel),
    .tx_ready(a_ready), .rx_data(a_rx), .done(a_done), .busy(a_busy),
    .ss_n(a_ss_n), .sclk(a_sclk), .mosi(a_mosi), .miso(a_miso)
  );

  spi_config_controller #(.CLK_DIV(1), .WORD_BITS(32), .SS_SETUP(1), .SS_HOLD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid && sel),
    .tx_ready(b_ready), .rx_data(b_rx), .done(b_done), .busy(b_busy),
    .ss_n(b_ss_n), .sclk(b_sclk), .mosi(b_mosi), .miso(b_miso)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 miso=0, 1 miso=1, 2 miso looped from mosi, 3 random miso
  task automatic xfer(input logic [31:0] word, input int mode, input logic [31:0] after_word,
                      input bit keep_valid, input int abort_bits);
    int t, cd, lat_exp, acc, rises, ss_low, fall_cyc;
    int hi_run, lo_run, hi_min, hi_max, lo_min, lo_max;
    logic [31:0] mw, model, exp_rx;
    logic [32:0] ent;
    logic prev_sclk, prev_miso, got, mosi_or;
    cd      = sel ? 1 : 4;
    lat_exp = sel ? 67 : 261;
    t = 0;
    while (!m_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", m_ready, 1'b1);
    tx_data  = word;
    tx_valid = 1'b1;
    miso_sel = mode;
    @(posedge clk);
    #1;
    acc = cyc;
    tx_data = after_word;
    if (!keep_valid) tx_valid = 1'b0;
`ifdef SPI_CTRL_RX_EN
    case (mode)
      0:       ent = {1'b0, 32'h0000_0000};
      1:       ent = {1'b0, 32'hFFFF_FFFF};
      2:       ent = {1'b0, word};
      default: ent = {1'b1, 32'h0000_0000};
    endcase
`else
    ent = 33'h0;
`endif
    sb_q.push_back(ent);
    rises = 0; ss_low = 0; fall_cyc = -1; hi_run = 0; lo_run = 0;
    hi_min = 9999; hi_max = 0; lo_min = 9999; lo_max = 0;
    mw = '0; model = '0; prev_sclk = 1'b0; prev_miso = m_miso; got = 1'b0; mosi_or = 1'b0;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      if (!m_ss_n) begin
        ss_low++;
        if (fall_cyc < 0) fall_cyc = cyc;
      end
      mosi_or = mosi_or | m_mosi;
      if (m_sclk && !prev_sclk) begin
        if (rises > 0) begin
          if (lo_run < lo_min) lo_min = lo_run;
          if (lo_run > lo_max) lo_max = lo_run;
        end
        lo_run = 0;
        rises++;
        mw    = {mw[30:0], m_mosi};
        model = {model[30:0], prev_miso};
      end
      if (m_sclk) begin
        hi_run++;
      end else begin
        if (prev_sclk) begin
          if (hi_run < hi_min) hi_min = hi_run;
          if (hi_run > hi_max) hi_max = hi_run;
          hi_run = 0;
        end
        if (rises > 0) lo_run++;
      end
      prev_sclk = m_sclk;
      prev_miso = m_miso;
      if (m_done) got = 1'b1;
      if (abort_bits > 0 && rises == abort_bits) break;
    end
    if (abort_bits > 0) begin
      ent = sb_q.pop_front();
      chk("abort_reached_bit", rises, abort_bits);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_ss_n", m_ss_n, 1'b1);
      chk("abort_sclk", m_sclk, 1'b0);
      chk("abort_mosi", m_mosi, 1'b0);
      chk("abort_done", m_done, 1'b0);
      chk("abort_busy", m_busy, 1'b0);
      chk("abort_ready", m_ready, 1'b1);
      chk("abort_rx", m_rx, 32'h0);
      rst_n = 1'b1;
      t = 0;
      for (int n = 0; n < 300; n++) begin
        @(negedge clk);
        if (m_done || !m_ss_n) t++;
      end
      chk("abort_quiet", t, 0);
      return;
    end
    chk("done_seen", got, 1'b1);
    chk("latency", cyc - acc, lat_exp);
    chk("ss_fall_cycle", fall_cyc, acc + 1);
    chk("ss_low_len", ss_low, lat_exp - 1);
    chk("sclk_rises", rises, 32);
    chk("mosi_word", mw, word);
    if (word == 32'h0) chk("mosi_stays_0", mosi_or, 1'b0);
    chk("sclk_hi_min", hi_min, cd);
    chk("sclk_hi_max", hi_max, cd);
    chk("sclk_lo_min", lo_min, cd);
    chk("sclk_lo_max", lo_max, cd);
    ent = sb_q.pop_front();
    exp_rx = ent[32] ? model : ent[31:0];
    chk("rx_data", m_rx, exp_rx);
    chk("done_busy", m_busy, 1'b1);
    chk("done_not_ready", m_ready, 1'b0);
    chk("done_ss_n", m_ss_n, 1'b1);
    last_done = cyc;
    last_acc  = acc;
    last_fall = fall_cyc;
    @(negedge clk);
    chk("post_ready", m_ready, 1'b1);
    chk("post_done", m_done, 1'b0);
    chk("post_rx_held", m_rx, exp_rx);
  endtask

  initial begin
    int d1;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", a_ss_n, 1'b1);
    chk("rst_sclk", a_sclk, 1'b0);
    chk("rst_mosi", a_mosi, 1'b0);
    chk("rst_ready", a_ready, 1'b1);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_rx", a_rx, 32'h0);
    chk("rst_b_ss_n", b_ss_n, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Looped word, then tx_data scrambled after accept.
    xfer(32'hA5C3_0F01, 2, 32'h5A3C_F0FE, 1'b0, 0);
    // All-zero word with miso tied high.
    xfer(32'h0000_0000, 1, 32'hFFFF_FFFF, 1'b0, 0);
    // Back-to-back with tx_valid held high across the first frame.
    xfer(32'h1234_5678, 2, 32'h9ABC_DEF0, 1'b1, 0);
    d1 = last_done;
    xfer(32'h9ABC_DEF0, 2, 32'h0BAD_F00D, 1'b0, 0);
    chk("accept_after_done", last_acc - d1, 2);
    chk("ss_gap_ge1", (last_fall - d1) >= 1, 1'b1);
    // Reset after 10 bits, then a clean transfer.
    xfer(32'hDEAD_BEEF, 2, 32'h0, 1'b0, 10);
    xfer(32'hC0FF_EE11, 2, 32'h0, 1'b0, 0);
    xfer(32'h8000_0001, 0, 32'h0, 1'b0, 0);
    // Fast instance.
    sel = 1'b1;
    @(negedge clk);
    xfer(32'h5A5A_00FF, 2, 32'h0, 1'b0, 0);
    xfer(32'hF0F0_1234, 1, 32'h0, 1'b0, 0);
    sel = 1'b0;
    @(negedge clk);
    // Random miso must not disturb the transmit trace.
    xfer(32'hA5C3_0F01, 3, 32'h0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
